fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 28 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/fifo_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter and its
//   round-robin selector.
//   - arb_state_t : arbiter FSM state (IDLE, GRANT)
//   - STALL_CNT_W : width of the saturating full-stall counter
//   - clog2()     : ceiling log2 with a floor of 1, used for index and
//                   beat counter widths
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Always at least 1 bit wide so a 1-requester or 1-beat configuration
    // still gets a legal vector.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Starting just after last_owner and
//   wrapping modulo NUM_REQ, returns the first index whose req bit is high.
//   Ports:
//     req        in  NUM_REQ         request vector
//     last_owner in  clog2(NUM_REQ)  index that was served most recently
//     found      out 1               any request high
//     idx        out clog2(NUM_REQ)  selected index (0 when found is low)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] last_owner,
    output logic                      found,
    output logic [clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = clog2(NUM_REQ);

    int cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        // Offsets 1..NUM_REQ visit every requester once, last_owner last.
        // The explicit wrap keeps non-power-of-two NUM_REQ correct.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_owner) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing the single write port of the async FIFO
//   among NUM_REQ requesters in the wr_clk domain. The owner holds the port
//   for up to MAX_BURST beats; beats pass straight through and stall while
//   fifo_full is high. Full-stall cycles are counted for debug.
//   Ports:
//     wr_clk       in  1                write-domain clock
//     reset_in     in  1                async active-low reset
//     req          in  NUM_REQ          per-requester valid
//     req_data     in  NUM_REQ*DATA_W   beat data, slot i at [i*DATA_W +: DATA_W]
//     req_last     in  NUM_REQ          final beat of a requester's burst
//     gnt          out NUM_REQ          per-requester ready (one-hot or zero)
//     fifo_full    in  1                FIFO full flag
//     fifo_wr_en   out 1                FIFO write enable
//     fifo_data_in out DATA_W           FIFO write data (0 when not writing)
//     active_id    out clog2(NUM_REQ)   current or last owner
//     busy         out 1                high while a grant is active
//     stall_cnt    out 16               saturating full-stall cycle count
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      wr_clk,
    input  logic                      reset_in,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [clog2(NUM_REQ)-1:0] active_id,
    output logic                      busy,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    localparam int IDX_W  = clog2(NUM_REQ);
    localparam int BEAT_W = clog2(MAX_BURST);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last_owner;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_found;
    logic [BEAT_W-1:0] beat_cnt;

    logic              own_req;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              xfer;
    logic              stall;
    logic              drop;
    logic              burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    assign own_req  = req[owner];
    assign own_last = req_last[owner];

    always_comb begin
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                own_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and per-cycle control. All grant/write outputs derive from
    // the registered state, so asserting reset drops them immediately.
    always_comb begin
        state_nxt = state;
        gnt       = '0;
        xfer      = 1'b0;
        stall     = 1'b0;
        drop      = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    gnt[i] = (owner == IDX_W'(i)) && !fifo_full;
                end
                xfer  = own_req && !fifo_full;
                stall = own_req && fifo_full;
                drop  = !own_req;
                // req_last and the beat limit on the same transfer are a
                // single end; a blocked req_last beat does not end anything.
                burst_end = xfer && (own_last || (beat_cnt == BEAT_W'(MAX_BURST - 1)));
                if (drop || burst_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fifo_wr_en   = xfer;
    assign fifo_data_in = xfer ? own_data : '0;
    assign busy         = (state == GRANT);
    assign active_id    = owner;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge wr_clk or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge wr_clk or negedge reset_in) begin
        if (!reset_in) begin
            owner      <= '0;
            // Search starts at last_owner+1, so this gives requester 0 first pick.
            last_owner <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
            stall_cnt  <= '0;
        end else begin
            if ((state == IDLE) && pick_found) begin
                owner    <= pick_idx;
                beat_cnt <= '0;
            end
            if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (drop || burst_end) begin
                last_owner <= owner;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8,
//   MAX_BURST=4): a vector table, hand-written multi-cycle sequences, and
//   random traffic compared against a transaction-level reference model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              wr_clk;
    logic              reset_in;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     gnt;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_data_in;
    logic [1:0]        active_id;
    logic              busy;
    logic [15:0]       stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .wr_clk       (wr_clk),
        .reset_in     (reset_in),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .active_id    (active_id),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  gnt;
        logic        wr;
        logic [7:0]  din;
        logic        busy;
        logic [1:0]  id;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 50) begin
                $display("FAIL %s: got %0h expected %0h", name, act, exp);
            end
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic wr,
                              input logic [7:0] d, input logic b, input logic [1:0] id);
        check({tag, ".gnt"},  32'(gnt),          32'(g));
        check({tag, ".wr"},   32'(fifo_wr_en),   32'(wr));
        check({tag, ".din"},  32'(fifo_data_in), 32'(d));
        check({tag, ".busy"}, 32'(busy),         32'(b));
        check({tag, ".id"},   32'(active_id),    32'(id));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked
    // 1 time unit later, well clear of the next edge.
    task automatic drive(input logic [3:0] r, input logic [31:0] d,
                         input logic [3:0] l, input logic f);
        req       = r;
        req_data  = d;
        req_last  = l;
        fifo_full = f;
        #1;
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_in = 1'b0;
        drive(4'b0, 32'b0, 4'b0, 1'b0);
        expect_out(tag, 4'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        check({tag, ".stall"}, 32'(stall_cnt), 32'd0);
        step();
        reset_in = 1'b1;
    endtask

    // Reference model: tracks who holds the port, how many beats it has
    // moved, and who was served last; arbitration is an explicit modulo scan.
    int m_busy, m_owner, m_last, m_beats, m_stall;

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = NR - 1;
        m_beats = 0;
        m_stall = 0;
    endtask

    task automatic model_cycle(input logic [3:0] r, input logic [31:0] d,
                               input logic [3:0] l, input logic f);
        logic [3:0] eg;
        logic       ew;
        logic [7:0] ed;
        eg = 4'b0;
        ew = 1'b0;
        ed = 8'h00;
        if (m_busy != 0) begin
            if (!f) eg[m_owner] = 1'b1;
            ew = r[m_owner] && !f;
            if (ew) ed = d[m_owner*8 +: 8];
        end
        expect_out("rand", eg, ew, ed, 1'(m_busy), 2'(m_owner));
        check("rand.stall", 32'(stall_cnt), 32'(m_stall));

        if (m_busy == 0) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (r[c]) begin
                    m_owner = c;
                    m_beats = 0;
                    m_busy  = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end else if (f) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            m_beats++;
            if (l[m_owner] || m_beats == MB) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
    endtask

    initial begin
        reset_in  = 1'b0;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;

        // ---------------- reset state ----------------
        #1;
        expect_out("reset", 4'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        check("reset.stall", 32'(stall_cnt), 32'd0);
        step();
        reset_in = 1'b1;

        // ---------------- vector table ----------------
        // Requester 2: 3-beat burst ending on req_last.
        vecs.push_back('{4'b0100, 32'hEE11CCDD, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 16'd0});
        vecs.push_back('{4'b0100, 32'hEE11CCDD, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h11, 1'b1, 2'd2, 16'd0});
        vecs.push_back('{4'b0100, 32'hEE22CCDD, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2, 16'd0});
        vecs.push_back('{4'b0100, 32'hEE33CCDD, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b1, 2'd2, 16'd0});
        vecs.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2, 16'd0});
        // Requester 1: fifo_full for 5 cycles after the first beat.
        vecs.push_back('{4'b0010, 32'h5566A177, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2, 16'd0});
        vecs.push_back('{4'b0010, 32'h5566A177, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1, 16'd0});
        for (int s = 0; s < 5; s++) begin
            vecs.push_back('{4'b0010, 32'h5566A277, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1, 16'(s)});
        end
        vecs.push_back('{4'b0010, 32'h5566A277, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'hA2, 1'b1, 2'd1, 16'd5});
        vecs.push_back('{4'b0010, 32'h5566A377, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'hA3, 1'b1, 2'd1, 16'd5});
        vecs.push_back('{4'b0010, 32'h5566A477, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'hA4, 1'b1, 2'd1, 16'd5});
        vecs.push_back('{4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1, 16'd5});

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].req, vecs[i].data, vecs[i].last, vecs[i].full);
            expect_out(tag, vecs[i].gnt, vecs[i].wr, vecs[i].din, vecs[i].busy, vecs[i].id);
            check({tag, ".stall"}, 32'(stall_cnt), 32'(vecs[i].stall));
            step();
        end

        // ---------------- all four requesting, no req_last ----------------
        do_reset("rst_rr");
        for (int b = 0; b < 5; b++) begin
            int o;
            o = b % NR;
            drive(4'b1111, 32'hD3C2B1A0, 4'b0000, 1'b0);
            check($sformatf("rr%0d.idle_busy", b), 32'(busy), 32'd0);
            check($sformatf("rr%0d.idle_wr", b), 32'(fifo_wr_en), 32'd0);
            step();
            for (int k = 0; k < MB; k++) begin
                expect_out($sformatf("rr%0d.beat%0d", b, k), 4'(1 << o), 1'b1,
                           8'(8'hA0 + 8'h11 * o), 1'b1, 2'(o));
                step();
            end
        end

        // ---------------- requester 3 abandons after one beat ----------------
        drive(4'b1000, 32'hD3C2B1A0, 4'b0000, 1'b0);
        check("drop.idle_busy", 32'(busy), 32'd0);
        step();
        expect_out("drop.beat0", 4'b1000, 1'b1, 8'hD3, 1'b1, 2'd3);
        step();
        drive(4'b0001, 32'hD3C2B1A0, 4'b0000, 1'b0);
        check("drop.abandon_wr", 32'(fifo_wr_en), 32'd0);
        check("drop.abandon_busy", 32'(busy), 32'd1);
        step();
        check("drop.idle_busy2", 32'(busy), 32'd0);
        step();
        for (int k = 0; k < MB; k++) begin
            expect_out($sformatf("drop.r0beat%0d", k), 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);
            step();
        end

        // ---------------- reset during beat 2 of requester 0 ----------------
        check("rstmid.idle_busy", 32'(busy), 32'd0);
        step();
        expect_out("rstmid.beat1", 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);
        step();
        expect_out("rstmid.beat2", 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);
        #1;
        reset_in = 1'b0;
        #1;
        check("rstmid.gnt", 32'(gnt), 32'd0);
        check("rstmid.wr", 32'(fifo_wr_en), 32'd0);
        check("rstmid.busy", 32'(busy), 32'd0);
        step();
        reset_in = 1'b1;
        drive(4'b0011, 32'hD3C2B1A0, 4'b0000, 1'b0);
        check("rstmid.idle_busy", 32'(busy), 32'd0);
        step();
        expect_out("rstmid.regrant", 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0);

        // ---------------- stall_cnt saturation ----------------
        do_reset("rst_sat");
        drive(4'b0001, 32'h000000AB, 4'b0000, 1'b1);
        step();
        for (int c = 0; c < 70000; c++) begin
            step();
        end
        check("sat.stall", 32'(stall_cnt), 32'h0000FFFF);
        check("sat.wr", 32'(fifo_wr_en), 32'd0);
        check("sat.busy", 32'(busy), 32'd1);
        fifo_full = 1'b0;
        #1;
        check("sat.resume_wr", 32'(fifo_wr_en), 32'd1);
        check("sat.resume_din", 32'(fifo_data_in), 32'h000000AB);

        // ---------------- random traffic vs reference model ----------------
        do_reset("rst_rand");
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [3:0]  r;
            logic [3:0]  l;
            logic [31:0] d;
            logic        f;
            r = 4'($urandom_range(0, 15));
            l = 4'b0;
            for (int j = 0; j < NR; j++) begin
                l[j] = ($urandom_range(0, 4) == 0);
            end
            d = $urandom;
            f = ($urandom_range(0, 3) == 0);
            drive(r, d, l, f);
            model_cycle(r, d, l, f);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
